// File: rtl/char_pkg.sv
// ---------------------------------------------------------------------------
// char_pkg
// Shared types and defaults for the character/element buffer sequencers
// (this write sequencer and the read-address incrementer).
//   state_t          : sequencer state encoding {IDLE, WRITE, DONE}
//   CHAR_ADDR_WIDTH  : default buffer address width
//   CHAR_DATA_WIDTH  : default element width
// ---------------------------------------------------------------------------
package char_pkg;

   localparam int CHAR_ADDR_WIDTH = 4;
   localparam int CHAR_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/char_wr_ptr.sv
// ---------------------------------------------------------------------------
// char_wr_ptr
// Loadable, incrementing write-address counter with an end-of-range compare.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (ptr -> 0)
//   load       : load ptr with load_val (priority over inc)
//   load_val   : value loaded on load
//   inc        : advance ptr by one
//   end_val    : last address of the range (inclusive)
//   ptr        : current address
//   at_end     : ptr equals end_val
// ---------------------------------------------------------------------------
module char_wr_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] end_val,
   output logic [W-1:0] ptr,
   output logic         at_end
);

   localparam logic [W-1:0] PTR_ONE = W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (inc) begin
         ptr <= ptr + PTR_ONE;
      end
   end

   // Compared before any increment, so the top never has to advance past
   // the last address and an end of 2^W-1 cannot wrap the pointer.
   assign at_end = (ptr == end_val);

endmodule

// File: rtl/char_wr_seq.sv
// ---------------------------------------------------------------------------
// char_wr_seq
// Write-side sequencer for the tensor core's character/element buffers.
// Accepts an element stream and writes it to consecutive buffer addresses
// from start_addr to end_addr inclusive, pulsing done when the range fills.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : begin a pass (only looked at in IDLE)
//   abort                 : end the current pass, no done
//   halt                  : pause acceptance (in_ready forced low)
//   start_addr, end_addr  : range, latched on an accepted start
//   in_valid, in_data     : element stream
//   in_ready              : sequencer accepts an element this cycle
//   mem_we/addr/wdata     : registered buffer write port
//   busy                  : state is not IDLE
//   done                  : one-cycle pulse, range completed
//   err                   : one-cycle pulse, start rejected (start > end)
//   wr_count              : elements written in the current/last pass
//   state_dbg             : current FSM state
//
// Build option: CHAR_WR_SEQ_WRAP_EN selects circular mode -- the pointer
// reloads start at the end of each pass, done pulses once per pass and the
// sequencer stays in WRITE until abort or reset.
// ---------------------------------------------------------------------------
module char_wr_seq
   import char_pkg::*;
#(
   parameter int ADDR_WIDTH = CHAR_ADDR_WIDTH,
   parameter int DATA_WIDTH = CHAR_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  halt,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   wr_count,
   output state_t                state_dbg
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] start_lat;
   logic [ADDR_WIDTH-1:0] end_lat;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] ptr_load_val;
   logic [ADDR_WIDTH:0]   cnt_base;
   logic                  at_end;
   logic                  range_bad;
   logic                  xfer;
   logic                  ptr_load;
   logic                  ptr_inc;
   logic                  wrap_hit;

   // Handshake: an element transfers on a rising edge where in_valid and
   // in_ready are both high and abort is low. in_ready depends only on
   // state and halt, never on in_valid; abort suppresses a same-cycle
   // transfer.
   assign in_ready  = (state == WRITE) && !halt;
   assign xfer      = in_ready && in_valid && !abort;
   assign range_bad = (start_addr > end_addr);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

`ifdef CHAR_WR_SEQ_WRAP_EN
   // done is high the cycle after a pass's final write; the count restarts
   // from zero from that cycle on.
   assign wrap_hit = xfer && at_end;
   assign cnt_base = done ? '0 : wr_count;
`else
   assign wrap_hit = 1'b0;
   assign cnt_base = wr_count;
`endif

   assign ptr_load     = ((state == IDLE) && start && !range_bad) || wrap_hit;
   assign ptr_load_val = (state == IDLE) ? start_addr : start_lat;
   assign ptr_inc      = xfer && !at_end;

   char_wr_ptr #(
      .W (ADDR_WIDTH)
   ) u_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ptr_load),
      .load_val (ptr_load_val),
      .inc      (ptr_inc),
      .end_val  (end_lat),
      .ptr      (wr_ptr),
      .at_end   (at_end)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         start_lat <= '0;
         end_lat   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wr_count  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (range_bad) begin
                     err <= 1'b1;
                  end else begin
                     start_lat <= start_addr;
                     end_lat   <= end_addr;
                     wr_count  <= '0;
                     state     <= WRITE;
                  end
               end
            end
            WRITE: begin
               wr_count <= cnt_base;
               if (abort) begin
                  state <= IDLE;
               end else if (xfer) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= wr_ptr;
                  mem_wdata <= in_data;
                  wr_count  <= cnt_base + CNT_ONE;
                  if (at_end) begin
                     // done lines up with the final write strobe.
                     done <= 1'b1;
`ifndef CHAR_WR_SEQ_WRAP_EN
                     state <= DONE;
`endif
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/char_wr_seq.md
Name: char_wr_seq

Overview:
- Write-side sequencer for the tensor core's character/element buffers; the opposite direction of the read-address incrementer.
- Accepts a valid/ready element stream and writes it into a buffer memory at consecutive addresses from start_addr to end_addr inclusive.
- Pulses done when the range is filled.
- Sits between a compute/result stream and a single-port buffer write port.

Parameters:
- ADDR_WIDTH, 4, buffer address width.
- DATA_WIDTH, 8, element width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a write pass; sampled only in IDLE.
- abort  in  1  terminate the current pass.
- halt  in  1  pause acceptance; in_ready is forced low.
- start_addr  in  ADDR_WIDTH  first address; latched on start.
- end_addr  in  ADDR_WIDTH  last address, inclusive; latched on start.
- in_valid  in  1  element valid.
- in_data  in  DATA_WIDTH  element.
- in_ready  out  1  sequencer can accept.
- mem_we  out  1  buffer write enable, registered.
- mem_addr  out  ADDR_WIDTH  buffer write address, registered.
- mem_wdata  out  DATA_WIDTH  buffer write data, registered.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse: range completed.
- err  out  1  one-cycle pulse: start rejected.
- wr_count  out  ADDR_WIDTH+1  elements written in the current/last pass.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE.
  - in_ready, mem_we, done, err, busy = 0.
  - mem_addr, mem_wdata, wr_count = 0.
  - Latched start/end addresses = 0.
  - Reset mid-pass abandons the pass; no done is issued.
- State IDLE: in_ready=0.
  - If start and start_addr > end_addr: err=1 for the next cycle; stay IDLE.
  - If start otherwise: latch both addresses, wr_ptr=start_addr, wr_count=0, go to WRITE.
- State WRITE: in_ready = !halt, combinational from state and halt.
  - A transfer occurs when in_valid && in_ready.
  - On transfer, the next cycle has mem_we=1, mem_addr=wr_ptr, mem_wdata=in_data, and wr_count increments.
  - Latency from handshake to write strobe is exactly 1 cycle.
  - No transfer: mem_we=0 next cycle; mem_addr and mem_wdata hold.
  - Transfer with wr_ptr != end_latched: wr_ptr+1.
  - Transfer with wr_ptr == end_latched: go to DONE. The compare happens before the increment, so end_addr = 2^ADDR_WIDTH-1 never wraps the pointer.
  - abort has priority over a same-cycle transfer: no write occurs, go to IDLE, no done.
  - halt and abort together: abort wins.
- State DONE, one cycle: done=1, in_ready=0, then IDLE.
  - start asserted while in DONE is ignored.
  - The final mem_we occurs in this same cycle.
- start outside IDLE is ignored.
- start_addr == end_addr: exactly one element is written.
- Full range 0..2^W-1: wr_count reaches 2^W, which is why wr_count is ADDR_WIDTH+1 bits wide.
- busy=1 in WRITE and DONE.

Optional Feature:
- Macro CHAR_WR_SEQ_WRAP_EN.
- Defined (circular mode):
  - A transfer at end_latched reloads wr_ptr=start_latched and stays in WRITE.
  - done pulses for one cycle per completed pass; wr_count resets to 0 after that write.
  - WRITE is left only by abort or reset; the DONE state is unused.
- Undefined: single-pass behaviour as above.

Decomposition:
- Package char_pkg:
  - State enum typedef {IDLE, WRITE, DONE}, 2-bit.
  - Default ADDR_WIDTH/DATA_WIDTH localparams, shared with the read incrementer.
- Optional sub-module char_wr_ptr holding the load/increment/compare address counter (load, inc, ptr, at_end). Otherwise a single module.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=8):
- Basic pass:
  - Stimulus: start, start_addr=2, end_addr=5, in_valid held high with data A0..A3.
  - Response: writes (2,A0)(3,A1)(4,A2)(5,A3) on consecutive cycles; done pulses once, aligned with the last mem_we; wr_count=4; then IDLE.
- Halt and backpressure:
  - Stimulus: halt asserted for 3 cycles mid-pass; in_valid toggled.
  - Response: in_ready=0 during halt; no mem_we without a handshake; address sequence has no gaps or duplicates.
- Bad range:
  - Stimulus: start with start_addr=9, end_addr=3.
  - Response: err pulses 1 cycle; busy stays 0; no mem_we.
- Edge ranges:
  - Stimulus 1: start_addr=end_addr=7. Response: one write at 7, then done.
  - Stimulus 2: range 0..15. Response: 16 writes, wr_count=16, no pointer wrap.
- Abort and reset:
  - Stimulus 1: abort coincident with a handshake at addr 4. Response: no write at 4; IDLE; no done.
  - Stimulus 2: rst_n low mid-pass. Response: all outputs return to reset values on the next edge.
- CHAR_WR_SEQ_WRAP_EN:
  - Stimulus: range 1..3, 7 elements.
  - Response: addresses 1,2,3,1,2,3,1; done pulses after the 3rd and 6th writes; still busy.
